// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//
// Computes one FIR output per accepted sample by driving an external multiply/add
// ALU. Each tap takes one multiply (x[k]*c[k]) and one accumulate-add
// (acc+product). Each operation holds its operands for ALU_LAT cycles and then
// captures ALU_ANS.
//
// Optional feature macro: FIR_MAC_SKIP_ZERO_EN. When it is defined, taps whose
// coefficient is zero issue no ALU operations.
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   IN_VALID/IN_READY     sample handshake; IN_SAMPLE is the new x[n]
//   COEF_WE/ADDR/DATA     coefficient bank write port (ignored while BUSY)
//   ALU_A/B/SELECT0       registered ALU operands; SELECT0 0 = multiply, 1 = add
//   ALU_ANS               ALU result
//   OUT_VALID/OUT_DATA    one-cycle result pulse; OUT_DATA holds its value afterwards
//   BUSY                  computation in progress (~IN_READY)
module fir_mac_sequencer #(
    parameter int unsigned W        = 38,
    parameter int unsigned TAPS     = 8,
    parameter int unsigned ALU_LAT  = 2,
    localparam int unsigned AW      = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  IN_SAMPLE,
    input  logic          COEF_WE,
    input  logic [AW-1:0] COEF_ADDR,
    input  logic [W-1:0]  COEF_DATA,
    output logic [W-1:0]  ALU_A,
    output logic [W-1:0]  ALU_B,
    output logic          ALU_SELECT0,
    input  logic [W-1:0]  ALU_ANS,
    output logic          OUT_VALID,
    output logic [W-1:0]  OUT_DATA,
    output logic          BUSY
);
    localparam int unsigned   CW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(ALU_LAT - 1);
    localparam logic [AW-1:0] TapLast = AW'(TAPS - 1);

    typedef enum logic [1:0] {StIdle, StMul, StAdd} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] tap_q, tap_d;
    logic [W-1:0]  x_q [TAPS];
    logic [W-1:0]  x_d [TAPS];
    logic [W-1:0]  c_q [TAPS];
    logic [W-1:0]  c_d [TAPS];
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic          alu_sel_q, alu_sel_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;

    logic          idle;
    logic          first_ok, next_ok;
    logic [AW-1:0] first_tap, next_tap;

    assign idle = (state_q == StIdle);

    // Coefficient bank. The written value is visible through c_d so a write in the
    // accept cycle feeds the computation that starts at the same edge.
    always_comb begin
        c_d = c_q;
        if (COEF_WE && idle && (32'(COEF_ADDR) < TAPS)) begin
            c_d[COEF_ADDR] = COEF_DATA;
        end
    end

`ifdef FIR_MAC_SKIP_ZERO_EN
    logic [TAPS-1:0] nz_acc, nz_run;

    // Lowest tap index >= start with a nonzero coefficient; MSB flags a hit.
    function automatic logic [AW:0] find_tap(input int unsigned start,
                                             input logic [TAPS-1:0] nz);
        logic [AW:0] r;
        r = '0;
        for (int i = int'(TAPS) - 1; i >= 0; i--) begin
            if (i >= int'(start) && nz[i]) r = {1'b1, AW'(i)};
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < int'(TAPS); k++) begin
            nz_acc[k] = |c_d[k];
            nz_run[k] = |c_q[k];
        end
        {first_ok, first_tap} = find_tap(0, nz_acc);
        {next_ok, next_tap}   = find_tap(32'(tap_q) + 1, nz_run);
    end
`else
    always_comb begin
        first_ok  = 1'b1;
        first_tap = '0;
        next_ok   = (tap_q != TapLast);
        next_tap  = tap_q + 1'b1;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tap_d       = tap_q;
        x_d         = x_q;
        acc_d       = acc_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    x_d[0] = IN_SAMPLE;
                    for (int k = 1; k < int'(TAPS); k++) x_d[k] = x_q[k-1];
                    acc_d = '0;
                    cnt_d = '0;
                    if (first_ok) begin
                        state_d   = StMul;
                        tap_d     = first_tap;
                        alu_a_d   = x_d[first_tap];
                        alu_b_d   = c_d[first_tap];
                        alu_sel_d = 1'b0;
                    end else begin
                        // Every coefficient is zero: result is known immediately.
                        out_valid_d = 1'b1;
                        out_data_d  = '0;
                    end
                end
            end
            StMul: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    state_d   = StAdd;
                    alu_a_d   = acc_q;
                    alu_b_d   = ALU_ANS;  // product forwarded straight into the add
                    alu_sel_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAdd: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    acc_d = ALU_ANS;
                    if (next_ok) begin
                        state_d   = StMul;
                        tap_d     = next_tap;
                        alu_a_d   = x_q[next_tap];
                        alu_b_d   = c_q[next_tap];
                        alu_sel_d = 1'b0;
                    end else begin
                        state_d     = StIdle;
                        out_valid_d = 1'b1;
                        out_data_d  = ALU_ANS;
                        alu_a_d     = '0;
                        alu_b_d     = '0;
                        alu_sel_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < int'(TAPS); k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            x_q         <= x_d;
            c_q         <= c_d;
        end
    end

    assign IN_READY    = idle;
    assign BUSY        = ~idle;
    assign ALU_A       = alu_a_q;
    assign ALU_B       = alu_b_q;
    assign ALU_SELECT0 = alu_sel_q;
    assign OUT_VALID   = out_valid_q;
    assign OUT_DATA    = out_data_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a behavioural ALU, a reference FIR model and an
// output scoreboard.
module tb_fir_mac_sequencer;
    localparam int unsigned W       = 38;
    localparam int unsigned TAPS    = 8;
    localparam int unsigned ALU_LAT = 2;
    localparam int unsigned AW      = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [W-1:0]  IN_SAMPLE = '0;
    logic          COEF_WE = 1'b0;
    logic [AW-1:0] COEF_ADDR = '0;
    logic [W-1:0]  COEF_DATA = '0;
    logic [W-1:0]  ALU_A, ALU_B, ALU_ANS;
    logic          ALU_SELECT0;
    logic          OUT_VALID;
    logic [W-1:0]  OUT_DATA;
    logic          BUSY;

    fir_mac_sequencer #(.W(W), .TAPS(TAPS), .ALU_LAT(ALU_LAT)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SAMPLE(IN_SAMPLE),
        .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SELECT0(ALU_SELECT0), .ALU_ANS(ALU_ANS),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // ALU: result passes ALU_LAT-1 register stages, so it is settled just before
    // the ALU_LAT-th edge after the operands change.
    logic [W-1:0] alu_f;
    logic [W-1:0] alu_pipe [ALU_LAT-1];
    assign alu_f   = ALU_SELECT0 ? (ALU_A + ALU_B) : (ALU_A * ALU_B);
    assign ALU_ANS = alu_pipe[ALU_LAT-2];
    always @(posedge CLK) begin
        alu_pipe[0] <= alu_f;
        for (int i = 1; i < int'(ALU_LAT) - 1; i++) alu_pipe[i] <= alu_pipe[i-1];
    end

    typedef struct {
        logic [W-1:0] y;
        int           e;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] xm [TAPS];
    logic [W-1:0] cm [TAPS];
    int           edge_n     = 0;  // index of the next rising edge
    int           busy_until = 0;  // model is idle at edges >= busy_until
    int           n_acc      = 0;
    int           n_cmp      = 0;
    int           n_bad      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    // Reference model: y[n] = sum c[k]*x[k] mod 2^W, decided at each rising edge.
    initial begin
        logic [W-1:0] y;
        int           nzc;
        int           lat;
        for (int k = 0; k < int'(TAPS); k++) begin
            xm[k] = '0;
            cm[k] = '0;
        end
        forever begin
            @(posedge CLK);
            if (!RESET && edge_n >= busy_until) begin
                if (COEF_WE && 32'(COEF_ADDR) < TAPS) cm[COEF_ADDR] = COEF_DATA;
                if (IN_VALID) begin
                    for (int k = int'(TAPS) - 1; k > 0; k--) xm[k] = xm[k-1];
                    xm[0] = IN_SAMPLE;
                    y   = '0;
                    nzc = 0;
                    for (int k = 0; k < int'(TAPS); k++) begin
                        y = y + cm[k] * xm[k];
                        if (cm[k] != '0) nzc++;
                    end
`ifdef FIR_MAC_SKIP_ZERO_EN
                    lat = 2 * int'(ALU_LAT) * nzc;
`else
                    lat = 2 * int'(ALU_LAT) * int'(TAPS);
`endif
                    sb.push_back('{y: y, e: edge_n + lat});
                    busy_until = edge_n + lat + 1;
                    n_acc++;
                end
            end
            edge_n++;
        end
    end

    // Monitor: handshake, idle ALU operands and result scoreboard, every cycle.
    initial begin
        exp_t e;
        bit   exp_ready;
        bit   exp_out;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                exp_ready = (edge_n >= busy_until);
                check("in_ready", 64'(IN_READY), 64'(exp_ready));
                check("busy", 64'(BUSY), 64'(!exp_ready));
                if (exp_ready) begin
                    check("idle_alu_a", 64'(ALU_A), 64'(0));
                    check("idle_alu_b", 64'(ALU_B), 64'(0));
                    check("idle_alu_sel", 64'(ALU_SELECT0), 64'(0));
                end
                exp_out = (sb.size() > 0) && (sb[0].e == edge_n - 1);
                check("out_valid", 64'(OUT_VALID), 64'(exp_out));
                if (exp_out) begin
                    e = sb.pop_front();
                    check("out_data", 64'(OUT_DATA), 64'(e.y));
                end
            end
        end
    end

    task automatic drive_reset();
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        sb.delete();
        busy_until = 0;
        for (int k = 0; k < int'(TAPS); k++) begin
            xm[k] = '0;
            cm[k] = '0;
        end
        #1;
        check("rst_in_ready", 64'(IN_READY), 64'(1));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_out_valid", 64'(OUT_VALID), 64'(0));
        check("rst_out_data", 64'(OUT_DATA), 64'(0));
        check("rst_alu_a", 64'(ALU_A), 64'(0));
        check("rst_alu_b", 64'(ALU_B), 64'(0));
        check("rst_alu_sel", 64'(ALU_SELECT0), 64'(0));
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
    endtask

    task automatic coef_write(input int a, input logic [W-1:0] d);
        @(negedge CLK);
        COEF_WE   = 1'b1;
        COEF_ADDR = AW'(a);
        COEF_DATA = d;
        @(negedge CLK);
        COEF_WE = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] s, input bit we, input int a, input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        while (edge_n < busy_until && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: waited %0d cycles, limit 300", n);
        end
        IN_VALID  = 1'b1;
        IN_SAMPLE = s;
        COEF_WE   = we;
        COEF_ADDR = AW'(a);
        COEF_DATA = d;
        @(negedge CLK);
        IN_VALID = 1'b0;
        COEF_WE  = 1'b0;
    endtask

    task automatic impulse_run();
        for (int k = 0; k < int'(TAPS); k++) coef_write(k, W'(k + 1));
        send(W'(1), 1'b0, 0, '0);
        for (int i = 0; i < 7; i++) send('0, 1'b0, 0, '0);
    endtask

    initial begin
        int last;
        bit wrote;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d results pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int  last;
        bit  wrote;
        int  n;
        logic [W-1:0] big;

        // Reset, then accept on the first edge after release.
        drive_reset();
        IN_VALID  = 1'b1;
        IN_SAMPLE = '0;
        @(negedge CLK);
        IN_VALID = 1'b0;

        // Impulse response 1..8.
        impulse_run();

        // Wraparound cases.
        for (int k = 0; k < int'(TAPS); k++) coef_write(k, '0);
        big = {1'b1, 37'd0};
        coef_write(0, big);
        send(W'(2), 1'b0, 0, '0);
        coef_write(0, W'(1));
        coef_write(1, W'(1));
        big = '1;
        send(big, 1'b0, 0, '0);
        send(W'(1), 1'b0, 0, '0);

        // Random coefficients and samples, same-cycle writes, writes while busy.
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 1)
                coef_write(int'($urandom_range(0, TAPS - 1)),
                           ($urandom_range(0, 3) == 0) ? '0 : rnd());
            send(rnd(), 1'($urandom_range(0, 1)), int'($urandom_range(0, TAPS - 1)), rnd());
            if ($urandom_range(0, 2) == 0) coef_write(int'($urandom_range(0, TAPS - 1)), rnd());
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        // IN_VALID held high continuously; one coefficient write lands while busy.
        @(negedge CLK);
        IN_VALID  = 1'b1;
        IN_SAMPLE = rnd();
        last      = n_acc;
        wrote     = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge CLK);
            if (n_acc != last) begin
                IN_SAMPLE = rnd();
                last      = n_acc;
            end
            if (COEF_WE) begin
                COEF_WE = 1'b0;
            end else if (!wrote && (busy_until - edge_n) > 5 && n_acc > last - 1) begin
                COEF_WE   = 1'b1;
                COEF_ADDR = AW'(2);
                COEF_DATA = rnd();
                wrote     = 1'b1;
            end
        end
        IN_VALID = 1'b0;
        COEF_WE  = 1'b0;
        send(W'(3), 1'b0, 0, '0);

        // Abort mid-computation, then repeat the impulse run.
        send(rnd(), 1'b0, 0, '0);
        repeat (9) @(negedge CLK);
        drive_reset();
        impulse_run();

        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        repeat (3) @(negedge CLK);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results never appeared, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
